// File: rtl/sorted_serializer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sorted_serializer_if
// Description : Bundle of the vector input, element stream output and status
//               signals of sorted_serializer.
//               slave  : view of the serializer itself
//               master : view of the environment (producer + consumer)
// Signals     : data_i         sorted vector, element 0 is the smallest
//               data_valid_i   single-cycle vector strobe (no backpressure)
//               data_o         current element
//               data_valid_o   element valid
//               data_ready_i   consumer ready
//               data_last_o    final element of a vector
//               index_o        vector index of the current element
//               fifo_level_o   vectors stored (excluding the one being sent)
//               overflow_o     sticky vector-dropped flag
//               overflow_clr_i clears overflow_o
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface sorted_serializer_if #(
   parameter int NUMBER_WIDTH   = 10,
   parameter int NUMBERS_AMOUNT = 10,
   parameter int FIFO_DEPTH     = 4
);
   localparam int c_IDX_W = $clog2(NUMBERS_AMOUNT);
   localparam int c_LVL_W = $clog2(FIFO_DEPTH + 1);

   logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] data_i;
   logic                                        data_valid_i;
   logic [NUMBER_WIDTH-1:0]                     data_o;
   logic                                        data_valid_o;
   logic                                        data_ready_i;
   logic                                        data_last_o;
   logic [c_IDX_W-1:0]                          index_o;
   logic [c_LVL_W-1:0]                          fifo_level_o;
   logic                                        overflow_o;
   logic                                        overflow_clr_i;

   modport slave (
      input  data_i,
      input  data_valid_i,
      input  data_ready_i,
      input  overflow_clr_i,
      output data_o,
      output data_valid_o,
      output data_last_o,
      output index_o,
      output fifo_level_o,
      output overflow_o
   );

   modport master (
      output data_i,
      output data_valid_i,
      output data_ready_i,
      output overflow_clr_i,
      input  data_o,
      input  data_valid_o,
      input  data_last_o,
      input  index_o,
      input  fifo_level_o,
      input  overflow_o
   );
endinterface
`default_nettype wire

// File: rtl/sorted_serializer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sorted_serializer
// Description : Back end of the sorting network. Whole sorted vectors are
//               captured into a small vector FIFO (the network cannot be
//               stalled) and streamed out one element per beat on a
//               valid/ready interface. Vectors arriving into a full FIFO are
//               dropped and flagged on a sticky overflow bit.
// Ports       : clk_i    clock, rising edge
//               rst_n_i  synchronous active-low reset
//               bus      sorted_serializer_if.slave (vector in, stream out,
//                        level / overflow status)
// Options     : SORTED_SERIALIZER_DESCENDING_EN - when defined, elements are
//               emitted from index NUMBERS_AMOUNT-1 down to 0 and data_last_o
//               marks index 0. Default build emits ascending order.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module sorted_serializer #(
   parameter int NUMBER_WIDTH   = 10,
   parameter int NUMBERS_AMOUNT = 10,
   parameter int FIFO_DEPTH     = 4
) (
   input wire              clk_i,
   input wire              rst_n_i,
   sorted_serializer_if.slave bus
);

   localparam int c_IDX_W = $clog2(NUMBERS_AMOUNT);
   localparam int c_LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int c_PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [c_IDX_W-1:0] c_IDX_MAX  = c_IDX_W'(NUMBERS_AMOUNT - 1);
   localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(FIFO_DEPTH);

`ifdef SORTED_SERIALIZER_DESCENDING_EN
   localparam logic [c_IDX_W-1:0] c_IDX_FIRST = c_IDX_MAX;
   localparam logic [c_IDX_W-1:0] c_IDX_LAST  = '0;
`else
   localparam logic [c_IDX_W-1:0] c_IDX_FIRST = '0;
   localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_MAX;
`endif

   typedef logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] vec_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   //---------------------------------------------------------------------------
   // Storage and state
   //---------------------------------------------------------------------------
   vec_t               r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_LVL_W-1:0] r_level;
   logic               r_overflow;

   state_t             r_state;
   state_t             w_state_nxt;
   vec_t               r_vec;       // vector currently being serialized
   logic [c_IDX_W-1:0] r_idx;
   logic [c_IDX_W-1:0] w_idx_nxt;

   logic               w_fifo_nempty;
   logic               w_pop;
   logic               w_push_acc;
   logic               w_drop;
   logic               w_hs;

   assign w_fifo_nempty = (r_level != '0);

   // A full FIFO still accepts a vector when the head leaves in the same
   // cycle: the freed slot is exactly the one the write pointer addresses.
   assign w_push_acc = bus.data_valid_i && ((r_level != c_LVL_FULL) || w_pop);
   assign w_drop     = bus.data_valid_i && !w_push_acc;

   //---------------------------------------------------------------------------
   // Read FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_vec   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_pop) begin
            r_vec <= r_mem[r_rd_ptr];
         end
      end
   end

   //---------------------------------------------------------------------------
   // Read FSM: next state, pop request and element index
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_pop       = 1'b0;
      w_hs        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_fifo_nempty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_SEND;
            end
         end

         ST_SEND: begin
            w_hs = bus.data_ready_i;
            if (w_hs) begin
               if (r_idx == c_IDX_LAST) begin
                  // Chain straight into the next vector so the stream has
                  // no bubble across vector boundaries.
                  if (w_fifo_nempty) begin
                     w_pop = 1'b1;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
`ifdef SORTED_SERIALIZER_DESCENDING_EN
                  w_idx_nxt = r_idx - 1'b1;
`else
                  w_idx_nxt = r_idx + 1'b1;
`endif
               end
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_pop) begin
         w_idx_nxt = c_IDX_FIRST;
      end
   end

   //---------------------------------------------------------------------------
   // Vector FIFO pointers, level and sticky overflow
   //---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end

         case ({w_push_acc, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase

         // A drop in the same cycle as a clear keeps the flag set.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (bus.overflow_clr_i) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // Vector storage needs no reset: only slots between the pointers are read.
   always_ff @(posedge clk_i) begin
      if (w_push_acc) begin
         r_mem[r_wr_ptr] <= bus.data_i;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs. Everything is driven from registers, so data/index/last hold
   // still while the consumer stalls.
   //---------------------------------------------------------------------------
   assign bus.data_valid_o = (r_state == ST_SEND);
   assign bus.data_o       = r_vec[r_idx];
   assign bus.index_o      = r_idx;
   assign bus.data_last_o  = (r_state == ST_SEND) && (r_idx == c_IDX_LAST);
   assign bus.fifo_level_o = r_level;
   assign bus.overflow_o   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sorted_serializer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_sorted_serializer
// Description : Randomized + directed bench for sorted_serializer. A queue
//               based reference model predicts accepted vectors, the element
//               stream, the FIFO level and the overflow flag; a monitor
//               compares the DUT against it every cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_sorted_serializer;

   localparam int NW = 8;
   localparam int NA = 4;
   localparam int FD = 2;
   localparam int IW = $clog2(NA);

   typedef logic [NA-1:0][NW-1:0] vec_t;
   typedef struct packed {
      logic [NW-1:0] d;
      logic [IW-1:0] idx;
      logic          last;
   } beat_t;

   logic clk_i   = 1'b0;
   logic rst_n_i = 1'b0;
   always #5 clk_i = ~clk_i;

   sorted_serializer_if #(.NUMBER_WIDTH(NW), .NUMBERS_AMOUNT(NA), .FIFO_DEPTH(FD)) bus ();

   sorted_serializer #(.NUMBER_WIDTH(NW), .NUMBERS_AMOUNT(NA), .FIFO_DEPTH(FD)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .bus     (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // k-th beat of a vector in emission order
   function automatic beat_t beat_of(input vec_t v, input int k);
      beat_t b;
      int    i;
`ifdef SORTED_SERIALIZER_DESCENDING_EN
      i = NA - 1 - k;
`else
      i = k;
`endif
      b.d    = v[i];
      b.idx  = IW'(i);
      b.last = (k == NA - 1);
      return b;
   endfunction

   function automatic vec_t mk(input logic [NW-1:0] e0, e1, e2, e3);
      vec_t v;
      v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3;
      return v;
   endfunction

   //---------------------------------------------------------------------------
   // Reference model: pending vectors as a queue, the vector on the wire as a
   // beat countdown, expected beats in a scoreboard queue.
   //---------------------------------------------------------------------------
   vec_t  m_q[$];
   beat_t exp_q[$];
   bit    m_sending  = 0;
   int    m_rem      = 0;
   bit    m_ovf      = 0;
   bit    m_rst_seen = 0;
   bit    m_live     = 0;

   always @(posedge clk_i) begin
      bit   pop;
      bit   acc;
      vec_t v;
      if (!rst_n_i) begin
         m_q.delete();
         exp_q.delete();
         m_sending  = 0;
         m_rem      = 0;
         m_ovf      = 0;
         m_rst_seen = 1;
         m_live     = 1;
      end else begin
         m_rst_seen = 0;
         pop = 0;
         if (!m_sending)
            pop = (m_q.size() > 0);
         else if (bus.data_ready_i && m_rem == 1)
            pop = (m_q.size() > 0);
         acc = bus.data_valid_i && ((m_q.size() < FD) || pop);
         if (m_sending && bus.data_ready_i) m_rem = m_rem - 1;
         if (pop) begin
            v = m_q.pop_front();
            for (int k = 0; k < NA; k++) exp_q.push_back(beat_of(v, k));
            m_rem     = NA;
            m_sending = 1;
         end else if (m_sending && m_rem == 0) begin
            m_sending = 0;
         end
         if (acc) m_q.push_back(bus.data_i);
         if (bus.data_valid_i && !acc) m_ovf = 1;
         else if (bus.overflow_clr_i)  m_ovf = 0;
      end
   end

   //---------------------------------------------------------------------------
   // Monitor (mid-cycle): status every cycle, beats on each handshake, and
   // stability while stalled.
   //---------------------------------------------------------------------------
   bit            p_stall = 0;
   logic [NW-1:0] p_d;
   logic [IW-1:0] p_idx;
   logic          p_last;

   always @(negedge clk_i) begin
      beat_t e;
      if (m_rst_seen) begin
         check("reset_outputs",
               {bus.data_valid_o, bus.data_o, bus.index_o, bus.data_last_o,
                bus.fifo_level_o, bus.overflow_o}, 64'd0);
         p_stall = 0;
      end else if (m_live) begin
         check("valid",    bus.data_valid_o, m_sending);
         check("level",    bus.fifo_level_o, m_q.size());
         check("overflow", bus.overflow_o,   m_ovf);
         if (p_stall)
            check("stall_stable", {bus.data_o, bus.index_o, bus.data_last_o},
                  {p_d, p_idx, p_last});
         if (bus.data_valid_o && bus.data_ready_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("beat", {bus.data_o, bus.index_o, bus.data_last_o}, e);
            end
         end
         p_stall = bus.data_valid_o && !bus.data_ready_i;
         p_d     = bus.data_o;
         p_idx   = bus.index_o;
         p_last  = bus.data_last_o;
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus: inputs change 2 time units after each rising edge
   //---------------------------------------------------------------------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk_i);
         #2;
      end
   endtask

   task automatic push(input vec_t v);
      bus.data_i       = v;
      bus.data_valid_i = 1'b1;
      step();
      bus.data_valid_i = 1'b0;
      bus.data_i       = vec_t'($urandom);
   endtask

   initial begin
      bit found;
      bus.data_i         = '0;
      bus.data_valid_i   = 1'b0;
      bus.data_ready_i   = 1'b0;
      bus.overflow_clr_i = 1'b0;
      rst_n_i            = 1'b0;

      // reset held with random activity on the inputs
      for (int i = 0; i < 3; i++) begin
         bus.data_i         = vec_t'($urandom);
         bus.data_valid_i   = 1'($urandom);
         bus.data_ready_i   = 1'($urandom);
         bus.overflow_clr_i = 1'($urandom);
         step();
      end
      rst_n_i            = 1'b1;
      bus.data_valid_i   = 1'b0;
      bus.overflow_clr_i = 1'b0;
      bus.data_ready_i   = 1'b1;
      step();

      // single vector
      push(mk(8'd3, 8'd7, 8'd9, 8'd12));
      step(8);

      // backpressure while index 1 is on the bus
      push(mk(8'd3, 8'd7, 8'd9, 8'd12));
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (bus.data_valid_o && bus.index_o == IW'(1)) found = 1;
         else step();
      end
      if (!found) check("bp_wait_timeout", 0, 1);
      bus.data_ready_i = 1'b0;
      step(3);
      bus.data_ready_i = 1'b1;
      step(8);

      // back-to-back vectors four cycles apart
      push(mk(8'd1, 8'd2, 8'd3, 8'd4));
      step(3);
      push(mk(8'd5, 8'd6, 8'd7, 8'd8));
      step(12);

      // overflow: one vector moves to the output register, two fill the FIFO,
      // the fourth is dropped
      bus.data_ready_i = 1'b0;
      push(mk(8'd11, 8'd12, 8'd13, 8'd14));
      push(mk(8'd21, 8'd22, 8'd23, 8'd24));
      push(mk(8'd31, 8'd32, 8'd33, 8'd34));
      push(mk(8'd41, 8'd42, 8'd43, 8'd44));
      step(2);
      bus.overflow_clr_i = 1'b1;
      step();
      bus.overflow_clr_i = 1'b0;
      step();
      bus.data_ready_i = 1'b1;
      step(16);

      // reset in the middle of a vector
      push(mk(8'd50, 8'd60, 8'd70, 8'd80));
      step(3);
      rst_n_i = 1'b0;
      step();
      rst_n_i = 1'b1;
      step();
      push(mk(8'd10, 8'd20, 8'd30, 8'd40));
      step(8);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         bus.data_i         = vec_t'($urandom);
         bus.data_valid_i   = ($urandom_range(0, 2) == 0);
         bus.data_ready_i   = ($urandom_range(0, 3) != 0);
         bus.overflow_clr_i = ($urandom_range(0, 15) == 0);
         rst_n_i            = ($urandom_range(0, 149) != 0);
         step();
      end

      // drain
      rst_n_i            = 1'b1;
      bus.data_valid_i   = 1'b0;
      bus.overflow_clr_i = 1'b0;
      bus.data_ready_i   = 1'b1;
      step(20);
      check("drain_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
